// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/meter pair: meter FSM encoding,
// default counter width and the duty range used by both sides.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } meter_state_t;

  localparam int CNT_W_DEF = 24;
  localparam int DUTY_MAX  = 100;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchroniser for the asynchronous PWM input followed by a one-flop edge
// detector producing single-cycle rise/fall pulses.
module pwm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic pwm_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_d;

  // Deliberately not reset: the chain keeps tracking the pin through a reset, so
  // a reset taken while the input is high cannot fabricate a rising edge.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    lvl_d  <= sync_q[SYNC_STAGES-1];
  end

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~lvl_d;
  assign fall = ~lvl & lvl_d;

endmodule

// File: rtl/pwm_meter.sv
// PWM period / high-time meter: publishes one rise-to-rise measurement per
// period and flags stuck-high, stuck-low and counter saturation.
//
//  state | meaning
//  IDLE  | disabled, counters cleared, stuck flags cleared
//  ARM   | waiting for the first rising edge of a measurement
//  HIGH  | input high, counting period and high time
//  LOW   | input low, counting period; next rise publishes
module pwm_meter
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cycles,
  output logic [CNT_W-1:0] high_cycles,
  output logic             meas_valid,
  output logic             overflow,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam int                IDLE_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_HIT = IDLE_W'(TIMEOUT - 1);

  meter_state_t      state, state_nxt;
  logic [CNT_W-1:0]  per_cnt, hi_cnt, hi_hold;
  logic              sat;
  logic [IDLE_W-1:0] idle_cnt;
  logic              lvl, rise, fall;
  logic              edge_any, active, tmo_hit, publish;

  pwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .clk    (clk),
    .pwm_in (pwm_in),
    .lvl    (lvl),
    .rise   (rise),
    .fall   (fall)
  );

  assign edge_any = rise | fall;
  assign active   = en && (state != ST_IDLE);
  assign tmo_hit  = active && !edge_any && (idle_cnt == IDLE_HIT);
  assign publish  = active && (state == ST_LOW) && rise;

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_ARM;
        ST_ARM:  if (rise) state_nxt = ST_HIGH;
        ST_HIGH: begin
          if (fall)         state_nxt = ST_LOW;
          else if (tmo_hit) state_nxt = ST_ARM;
        end
        ST_LOW:  if (rise) state_nxt = ST_HIGH;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      per_cnt       <= '0;
      hi_cnt        <= '0;
      hi_hold       <= '0;
      sat           <= 1'b0;
      idle_cnt      <= '0;
      period_cycles <= '0;
      high_cycles   <= '0;
      meas_valid    <= 1'b0;
      overflow      <= 1'b0;
      stuck_high    <= 1'b0;
      stuck_low     <= 1'b0;
    end else begin
      state      <= state_nxt;
      meas_valid <= publish;
      if (publish) begin
        period_cycles <= per_cnt;
        high_cycles   <= hi_hold;
        overflow      <= sat;
      end

      if (!active) begin
        per_cnt    <= '0;
        hi_cnt     <= '0;
        sat        <= 1'b0;
        idle_cnt   <= '0;
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
      end else begin
        if (rise) begin
          per_cnt <= CNT_W'(1);
          hi_cnt  <= CNT_W'(1);
          sat     <= 1'b0;
        end else begin
          if (per_cnt == CNT_MAX) sat <= 1'b1;
          else                    per_cnt <= per_cnt + CNT_W'(1);
          if (state == ST_HIGH && !fall) begin
            if (hi_cnt == CNT_MAX) sat <= 1'b1;
            else                   hi_cnt <= hi_cnt + CNT_W'(1);
          end
        end
        if (fall) hi_hold <= hi_cnt;

        // Saturating at TIMEOUT makes each timeout fire exactly once per quiet spell.
        if (edge_any)                   idle_cnt <= '0;
        else if (idle_cnt != IDLE_MAX)  idle_cnt <= idle_cnt + IDLE_W'(1);

        if (edge_any) begin
          stuck_high <= 1'b0;
          stuck_low  <= 1'b0;
        end else if (tmo_hit) begin
          if (state == ST_HIGH) begin
            stuck_high <= 1'b1;
            stuck_low  <= 1'b0;
          end else if (state == ST_LOW || (state == ST_ARM && !lvl)) begin
            stuck_low  <= 1'b1;
            stuck_high <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_meter.sv
// Scoreboard bench for pwm_meter: a wide-counter instance, a 4-bit counter
// instance and a short-timeout instance all watch the same PWM stimulus.
module tb_pwm_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, en_t, pwm_in;

  logic [23:0] m_per, m_hi;
  logic        m_val, m_ov, m_sh, m_sl;
  logic [3:0]  s_per, s_hi;
  logic        s_val, s_ov, s_sh, s_sl;
  logic [23:0] t_per, t_hi;
  logic        t_val, t_ov, t_sh, t_sl;

  pwm_meter #(.CNT_W(24), .SYNC_STAGES(2), .TIMEOUT(1000000)) u_main (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
    .period_cycles(m_per), .high_cycles(m_hi), .meas_valid(m_val),
    .overflow(m_ov), .stuck_high(m_sh), .stuck_low(m_sl)
  );

  pwm_meter #(.CNT_W(4), .SYNC_STAGES(2), .TIMEOUT(1000000)) u_small (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
    .period_cycles(s_per), .high_cycles(s_hi), .meas_valid(s_val),
    .overflow(s_ov), .stuck_high(s_sh), .stuck_low(s_sl)
  );

  pwm_meter #(.CNT_W(24), .SYNC_STAGES(2), .TIMEOUT(64)) u_tmo (
    .clk(clk), .rst(rst), .en(en_t), .pwm_in(pwm_in),
    .period_cycles(t_per), .high_cycles(t_hi), .meas_valid(t_val),
    .overflow(t_ov), .stuck_high(t_sh), .stuck_low(t_sl)
  );

  typedef struct {
    int per;
    int hi;
    bit ov;
  } meas_t;

  meas_t q_m[$];
  meas_t q_s[$];
  int n_tests = 0;
  int n_fail  = 0;
  int last_m_per = 0, last_m_hi = 0;
  int t_valids = 0;
  bit prev_ok;
  int prev_p, prev_h;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a period of P cycles with H high reads back as P/H, clipped to the
  // counter range, with overflow whenever the period does not fit.
  task automatic push_exp(input int p, input int h);
    q_m.push_back('{per: p, hi: h, ov: 1'b0});
    q_s.push_back('{per: (p > 15) ? 15 : p, hi: (h > 15) ? 15 : h, ov: (p > 15)});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic gen_period(input int p, input int h);
    if (prev_ok) push_exp(prev_p, prev_h);
    pwm_in = 1'b1;
    cyc(h);
    pwm_in = 1'b0;
    cyc(p - h);
    prev_ok = 1'b1;
    prev_p  = p;
    prev_h  = h;
  endtask

  task automatic extend_low(input int n);
    cyc(n);
    if (prev_ok) prev_p += n;
  endtask

  always @(negedge clk) begin
    if (m_val === 1'b1) begin : mon_main
      meas_t e;
      if (q_m.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL main_unexpected_valid: got period %0d high %0d, expected no result", m_per, m_hi);
      end else begin
        e = q_m.pop_front();
        check("main_period", m_per, e.per);
        check("main_high", m_hi, e.hi);
        check("main_overflow", m_ov, e.ov);
        last_m_per = e.per;
        last_m_hi  = e.hi;
      end
    end
  end

  always @(negedge clk) begin
    if (s_val === 1'b1) begin : mon_small
      meas_t e;
      if (q_s.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL small_unexpected_valid: got period %0d high %0d, expected no result", s_per, s_hi);
      end else begin
        e = q_s.pop_front();
        check("small_period", s_per, e.per);
        check("small_high", s_hi, e.hi);
        check("small_overflow", s_ov, e.ov);
      end
    end
  end

  always @(negedge clk) if (t_val === 1'b1) t_valids++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, h;
    rst = 1'b0; en = 1'b0; en_t = 1'b0; pwm_in = 1'b0; prev_ok = 1'b0;
    cyc(5);
    check("rst_main_period", m_per, 0);
    check("rst_main_high", m_hi, 0);
    check("rst_main_valid", m_val, 0);
    check("rst_main_overflow", m_ov, 0);
    check("rst_main_flags", {m_sh, m_sl}, 0);
    check("rst_small_outputs", {s_per, s_hi, s_val, s_ov, s_sh, s_sl}, 0);
    check("rst_tmo_flags", {t_val, t_sh, t_sl}, 0);
    rst = 1'b1;

    // Held low from enable: short-timeout instance must flag stuck_low only.
    en = 1'b1; en_t = 1'b1;
    cyc(60);
    check("tmo_stuck_low_early", t_sl, 0);
    cyc(20);
    check("tmo_stuck_low_set", t_sl, 1);
    check("tmo_stuck_high_clear", t_sh, 0);
    check("main_no_stuck_low", m_sl, 0);
    en_t = 1'b0;
    cyc(2);
    check("tmo_flag_cleared_by_en", t_sl, 0);

    repeat (4) gen_period(20, 5);
    repeat (3) gen_period(100, 65);
    repeat (3) gen_period(100, 25);
    gen_period(20, 5); gen_period(20, 5); gen_period(10, 5); gen_period(10, 5);
    gen_period(2, 1); gen_period(3, 1); gen_period(16, 15); gen_period(15, 14);
    gen_period(17, 1); gen_period(15, 1);
    repeat (20) begin
      p = $urandom_range(60, 2);
      h = $urandom_range(p - 1, 1);
      gen_period(p, h);
    end

    // Disable while low: results hold, and the open period is discarded.
    extend_low(6);
    en = 1'b0;
    cyc(2);
    check("en0_period_held", m_per, last_m_per);
    check("en0_high_held", m_hi, last_m_hi);
    check("en0_no_valid", m_val, 0);
    en = 1'b1;
    prev_ok = 1'b0;
    cyc(3);
    repeat (3) gen_period(30, 10);

    // Held high after one rise: stuck_high on the short-timeout instance, cleared by the fall.
    en_t = 1'b1;
    extend_low(5);
    if (prev_ok) push_exp(prev_p, prev_h);
    pwm_in = 1'b1;
    cyc(60);
    check("tmo_stuck_high_early", t_sh, 0);
    cyc(20);
    check("tmo_stuck_high_set", t_sh, 1);
    check("tmo_stuck_low_clear", t_sl, 0);
    check("main_no_stuck_high", m_sh, 0);
    pwm_in = 1'b0;
    cyc(6);
    check("tmo_stuck_high_released", t_sh, 0);
    en_t = 1'b0;
    prev_ok = 1'b1; prev_p = 86; prev_h = 80;
    repeat (2) gen_period(20, 5);

    // One-cycle reset in the middle of a high phase.
    push_exp(prev_p, prev_h);
    pwm_in = 1'b1;
    cyc(6);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    check("midrst_main_outputs", {m_per, m_hi, m_val, m_ov, m_sh, m_sl}, 0);
    check("midrst_small_outputs", {s_per, s_hi, s_val, s_ov, s_sh, s_sl}, 0);
    last_m_per = 0; last_m_hi = 0;
    prev_ok = 1'b0;
    cyc(4);
    pwm_in = 1'b0;
    cyc(10);
    gen_period(20, 5);
    gen_period(20, 5);
    gen_period(40, 12);
    gen_period(40, 12);
    cyc(12);

    check("main_queue_drained", q_m.size(), 0);
    check("small_queue_drained", q_s.size(), 0);
    check("tmo_never_published", t_valids, 0);
    check("main_final_period", m_per, 40);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
